// File: rtl/flash_cmd_scheduler_pkg.sv
// Shared types and constants for the flash command scheduler: FSM states,
// grant source encodings and the default opcode bytes.
package flash_cmd_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    localparam logic [1:0] GID_ERASE = 2'd0;
    localparam logic [1:0] GID_WRITE = 2'd1;
    localparam logic [1:0] GID_READ  = 2'd2;

    localparam logic [7:0] OPC_E_DEF = 8'h60;
    localparam logic [7:0] OPC_W_DEF = 8'h80;
    localparam logic [7:0] OPC_R_DEF = 8'h00;

    localparam int N_SRC = 3;
    localparam int ROW_W = 24;
    localparam int CMD_W = 32;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/flash_cmd_scheduler_rr_arbiter3.sv
// Three-input round-robin arbiter: the search starts at the source after
// the last grant and wraps erase -> write -> read -> erase.
module rr_arbiter3
    import flash_cmd_scheduler_pkg::*;
(
    input  logic [2:0] i_pend,
    input  logic [1:0] i_last,
    output logic [1:0] o_gnt,
    output logic       o_valid
);

    logic [1:0] w_first;

    // NOTE: every output of a combinational block gets a default first,
    // so no path through the block leaves it unassigned (no latch).
    always_comb begin
        o_gnt   = GID_ERASE;
        o_valid = |i_pend;
        w_first = (i_last == GID_READ) ? GID_ERASE : i_last + 2'd1;
        // Walk from lowest to highest priority so the nearest candidate wins.
        for (int k = 2; k >= 0; k--) begin
            int idx;
            idx = (int'(w_first) + k) % 3;
            if (i_pend[idx]) begin
                o_gnt = 2'(idx);
            end
        end
    end

endmodule

// File: rtl/flash_cmd_scheduler.sv
// Flash command scheduler: latches erase/write/read requests, arbitrates them
// round-robin and sequences each operation through ISSUE, WAIT and GAP.
module flash_cmd_scheduler
    import flash_cmd_scheduler_pkg::*;
#(
    parameter int         TIMEOUT_CYC = 2000000,
    parameter int         GAP_CYC     = 4,
    parameter logic [7:0] OPC_E       = OPC_E_DEF,
    parameter logic [7:0] OPC_W       = OPC_W_DEF,
    parameter logic [7:0] OPC_R       = OPC_R_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_e,
    input  logic             req_w,
    input  logic             req_r,
    input  logic [ROW_W-1:0] row_e,
    input  logic [ROW_W-1:0] row_w,
    input  logic [ROW_W-1:0] row_r,
    input  logic             op_done,
    input  logic             clr_err,
    output logic [CMD_W-1:0] cmd,
    output logic             start_cmd,
    output logic [1:0]       grant_id,
    output logic             busy,
    output logic [2:0]       pend,
    output logic             timeout_err,
    output logic             overrun
);

    localparam int             WD_W     = cnt_width(TIMEOUT_CYC);
    localparam int             GAP_W    = cnt_width(GAP_CYC);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

    state_t             r_state;
    state_t             w_next;
    logic [WD_W-1:0]    r_wd_cnt;
    logic [GAP_W-1:0]   r_gap_cnt;
    logic [2:0]         r_pend;
    logic [ROW_W-1:0]   r_row [N_SRC];
    logic [CMD_W-1:0]   r_cmd;
    logic [1:0]         r_grant_id;
    logic               r_timeout_err;
    logic               r_overrun;

    logic [2:0]         w_req;
    logic [ROW_W-1:0]   w_row_in [N_SRC];
    logic [2:0]         w_clr;
    logic [2:0]         w_ovr_ev;
    logic [1:0]         w_arb_gnt;
    logic               w_arb_valid;
    logic               w_wd_last;
    logic               w_timeout_ev;
    logic               w_gap_last;
    logic               w_grant_load;
    logic [7:0]         w_sel_opc;
    logic [ROW_W-1:0]   w_sel_row;

    assign w_req       = {req_r, req_w, req_e};
    assign w_row_in[0] = row_e;
    assign w_row_in[1] = row_w;
    assign w_row_in[2] = row_r;

    rr_arbiter3 u_arb (
        .i_pend  (r_pend),
        .i_last  (r_grant_id),
        .o_gnt   (w_arb_gnt),
        .o_valid (w_arb_valid)
    );

    assign w_wd_last    = (r_wd_cnt == WD_LAST);
    assign w_gap_last   = (r_gap_cnt == GAP_LAST);
    // A completion on the expiry cycle counts as done, not as a timeout.
    assign w_timeout_ev = (r_state == ST_WAIT) && !op_done && w_wd_last;
    assign w_grant_load = (r_state == ST_IDLE) && w_arb_valid;

    // ---------------- FSM: state register ----------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:  if (w_arb_valid)           w_next = ST_ISSUE;
            ST_ISSUE:                            w_next = ST_WAIT;
            ST_WAIT:  if (op_done || w_wd_last)  w_next = ST_GAP;
            ST_GAP:   if (w_gap_last)            w_next = ST_IDLE;
            default:                             w_next = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        start_cmd = (r_state == ST_ISSUE);
        busy      = (r_state != ST_IDLE);
    end

    // Per-state counters restart at zero on every entry and never wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wd_cnt  <= '0;
            r_gap_cnt <= '0;
        end else begin
            if (r_state == ST_WAIT && w_next == ST_WAIT) begin
                r_wd_cnt <= r_wd_cnt + WD_W'(1);
            end else begin
                r_wd_cnt <= '0;
            end
            if (r_state == ST_GAP && w_next == ST_GAP) begin
                r_gap_cnt <= r_gap_cnt + GAP_W'(1);
            end else begin
                r_gap_cnt <= '0;
            end
        end
    end

    // A grant clears its pending flag at the end of ISSUE; a request landing
    // on that same cycle re-arms it, otherwise a request on a set flag is lost.
    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            w_clr[i]    = (r_state == ST_ISSUE) && (r_grant_id == 2'(i));
            w_ovr_ev[i] = w_req[i] && r_pend[i] && !w_clr[i];
        end
    end

    // NOTE: the three row registers are plain flops, not a RAM, so they are
    // reset like any other state to give a defined cmd after power-up.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pend <= '0;
            for (int i = 0; i < N_SRC; i++) begin
                r_row[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_SRC; i++) begin
                if (w_req[i] && !w_ovr_ev[i]) begin
                    r_pend[i] <= 1'b1;
                    r_row[i]  <= w_row_in[i];
                end else if (w_clr[i]) begin
                    r_pend[i] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        w_sel_opc = OPC_E;
        w_sel_row = r_row[0];
        unique case (w_arb_gnt)
            GID_WRITE: begin
                w_sel_opc = OPC_W;
                w_sel_row = r_row[1];
            end
            GID_READ: begin
                w_sel_opc = OPC_R;
                w_sel_row = r_row[2];
            end
            default: begin
                w_sel_opc = OPC_E;
                w_sel_row = r_row[0];
            end
        endcase
    end

    // cmd and grant_id are captured on IDLE -> ISSUE and held until the next grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cmd      <= '0;
            r_grant_id <= GID_READ;
        end else if (w_grant_load) begin
            r_cmd      <= {w_sel_opc, w_sel_row};
            r_grant_id <= w_arb_gnt;
        end
    end

    // Sticky error flags: a new event on the clearing cycle keeps the flag set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_timeout_err <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            if (w_timeout_ev) begin
                r_timeout_err <= 1'b1;
            end else if (clr_err) begin
                r_timeout_err <= 1'b0;
            end
            if (|w_ovr_ev) begin
                r_overrun <= 1'b1;
            end else if (clr_err) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign cmd         = r_cmd;
    assign grant_id    = r_grant_id;
    assign pend        = r_pend;
    assign timeout_err = r_timeout_err;
    assign overrun     = r_overrun;

endmodule

// File: tb/tb_flash_cmd_scheduler.sv
// Directed testbench for flash_cmd_scheduler: one task per scenario, inputs
// driven and outputs sampled on the falling clock edge.
module tb_flash_cmd_scheduler;

    localparam int TO  = 100;
    localparam int GAP = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_e = 1'b0, req_w = 1'b0, req_r = 1'b0;
    logic [23:0] row_e = '0, row_w = '0, row_r = '0;
    logic        op_done = 1'b0, clr_err = 1'b0;
    logic [31:0] cmd;
    logic        start_cmd;
    logic [1:0]  grant_id;
    logic        busy;
    logic [2:0]  pend;
    logic        timeout_err, overrun;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    localparam logic [40:0] RESET_VEC = {32'h0, 1'b0, 2'd2, 1'b0, 3'b000, 1'b0, 1'b0};

    flash_cmd_scheduler #(
        .TIMEOUT_CYC (TO),
        .GAP_CYC     (GAP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_e       (req_e),
        .req_w       (req_w),
        .req_r       (req_r),
        .row_e       (row_e),
        .row_w       (row_w),
        .row_r       (row_r),
        .op_done     (op_done),
        .clr_err     (clr_err),
        .cmd         (cmd),
        .start_cmd   (start_cmd),
        .grant_id    (grant_id),
        .busy        (busy),
        .pend        (pend),
        .timeout_err (timeout_err),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic apply_reset();
        req_e = 1'b0; req_w = 1'b0; req_r = 1'b0;
        op_done = 1'b0; clr_err = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_start(input string tag, input int budget, output int waited);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (start_cmd !== 1'b1 && waited < budget);
        if (start_cmd !== 1'b1) begin
            n_chk++;
            $display("FAIL %s: no start_cmd within %0d cycles", tag, budget);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy !== 1'b0) begin
            n_chk++;
            $display("FAIL %s: busy still high after %0d cycles", tag, n);
        end
    endtask

    task automatic pulse_done();
        op_done = 1'b1;
        @(negedge clk);
        op_done = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_chk++;
        if ({cmd, start_cmd, grant_id, busy, pend, timeout_err, overrun} !== RESET_VEC)
            $display("FAIL reset_values: got %h required %h",
                     {cmd, start_cmd, grant_id, busy, pend, timeout_err, overrun}, RESET_VEC);
        else n_pass++;
    endtask

    task automatic test_single_write();
        bit saw;
        apply_reset();
        req_w = 1'b1; row_w = 24'h000123;
        @(negedge clk);
        req_w = 1'b0;
        n_chk++;
        if ({pend, start_cmd} !== {3'b010, 1'b0})
            $display("FAIL write_pend: got pend=%b start=%b required pend=010 start=0", pend, start_cmd);
        else n_pass++;
        @(negedge clk);
        n_chk++;
        if ({start_cmd, cmd, grant_id, busy} !== {1'b1, 32'h80000123, 2'd1, 1'b1})
            $display("FAIL write_issue: got start=%b cmd=%h gid=%0d busy=%b required 1 80000123 1 1",
                     start_cmd, cmd, grant_id, busy);
        else n_pass++;
        @(negedge clk);
        pulse_done();
        wait_idle("write_idle");
        // op_done while idle must not trigger anything
        pulse_done();
        saw = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (start_cmd === 1'b1 || busy === 1'b1) saw = 1'b1;
        end
        n_chk++;
        if (saw !== 1'b0) $display("FAIL idle_done_ignored: got activity=%b required 0", saw);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [31:0] exp_cmd [3];
        int waited;
        int prev;
        exp_cmd[0] = 32'h60000011;
        exp_cmd[1] = 32'h80000022;
        exp_cmd[2] = 32'h00000033;
        apply_reset();
        req_e = 1'b1; req_w = 1'b1; req_r = 1'b1;
        row_e = 24'h000011; row_w = 24'h000022; row_r = 24'h000033;
        @(negedge clk);
        req_e = 1'b0; req_w = 1'b0; req_r = 1'b0;
        n_chk++;
        if (pend !== 3'b111) $display("FAIL rr_pend: got %b required 111", pend);
        else n_pass++;
        wait_start("rr_start0", 10, waited);
        n_chk++;
        if (waited !== 1) $display("FAIL rr_latency: got %0d extra cycles required 1", waited);
        else n_pass++;
        prev = cyc;
        for (int g = 0; g < 3; g++) begin
            if (g > 0) begin
                wait_start("rr_start", 40, waited);
                // ISSUE + 10 WAIT + 4 GAP + 1 IDLE
                n_chk++;
                if (cyc - prev !== 16)
                    $display("FAIL rr_spacing%0d: got %0d cycles required 16", g, cyc - prev);
                else n_pass++;
                prev = cyc;
            end
            n_chk++;
            if ({grant_id, cmd} !== {2'(g), exp_cmd[g]})
                $display("FAIL rr_grant%0d: got gid=%0d cmd=%h required gid=%0d cmd=%h",
                         g, grant_id, cmd, g, exp_cmd[g]);
            else n_pass++;
            repeat (10) @(negedge clk);
            pulse_done();
        end
        wait_idle("rr_idle");
    endtask

    task automatic test_overrun();
        apply_reset();
        req_r = 1'b1; row_r = 24'hAAAAAA;
        @(negedge clk);
        row_r = 24'h555555;
        @(negedge clk);
        req_r = 1'b0;
        n_chk++;
        if ({start_cmd, cmd, grant_id, overrun} !== {1'b1, 32'h00AAAAAA, 2'd2, 1'b1})
            $display("FAIL overrun_set: got start=%b cmd=%h gid=%0d ovr=%b required 1 00aaaaaa 2 1",
                     start_cmd, cmd, grant_id, overrun);
        else n_pass++;
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        n_chk++;
        if ({overrun, pend} !== {1'b0, 3'b000})
            $display("FAIL overrun_clear: got ovr=%b pend=%b required 0 000", overrun, pend);
        else n_pass++;
        pulse_done();
        wait_idle("overrun_idle");
    endtask

    task automatic test_timeout();
        int waited;
        apply_reset();
        req_e = 1'b1; row_e = 24'h000ABC;
        @(negedge clk);
        req_e = 1'b0;
        wait_start("to_start", 10, waited);
        repeat (100) @(negedge clk);
        n_chk++;
        if ({timeout_err, busy} !== 2'b01)
            $display("FAIL timeout_early: got err=%b busy=%b required 0 1", timeout_err, busy);
        else n_pass++;
        @(negedge clk);
        n_chk++;
        if ({timeout_err, busy} !== 2'b11)
            $display("FAIL timeout_set: got err=%b busy=%b required 1 1", timeout_err, busy);
        else n_pass++;
        repeat (3) @(negedge clk);
        n_chk++;
        if (busy !== 1'b1) $display("FAIL timeout_gap: got busy=%b required 1", busy);
        else n_pass++;
        @(negedge clk);
        n_chk++;
        if (busy !== 1'b0) $display("FAIL timeout_idle: got busy=%b required 0", busy);
        else n_pass++;
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        n_chk++;
        if (timeout_err !== 1'b0) $display("FAIL timeout_clear: got %b required 0", timeout_err);
        else n_pass++;
    endtask

    task automatic test_same_cycle();
        int waited;
        apply_reset();
        req_e = 1'b1; row_e = 24'h000001;
        @(negedge clk);
        req_e = 1'b0;
        wait_start("same_start0", 10, waited);
        req_e = 1'b1; row_e = 24'h000002;
        @(negedge clk);
        req_e = 1'b0;
        n_chk++;
        if ({pend, overrun} !== {3'b001, 1'b0})
            $display("FAIL same_pend: got pend=%b ovr=%b required 001 0", pend, overrun);
        else n_pass++;
        pulse_done();
        wait_start("same_start1", 40, waited);
        n_chk++;
        if ({grant_id, cmd} !== {2'd0, 32'h60000002})
            $display("FAIL same_reissue: got gid=%0d cmd=%h required 0 60000002", grant_id, cmd);
        else n_pass++;
        @(negedge clk);
        pulse_done();
        wait_idle("same_idle");
    endtask

    task automatic test_reset_mid();
        int waited;
        bit saw;
        apply_reset();
        req_w = 1'b1; row_w = 24'h000456;
        @(negedge clk);
        req_w = 1'b0;
        wait_start("mid_start", 10, waited);
        @(negedge clk);
        #2;
        rst = 1'b0;
        req_r = 1'b1;
        #1;
        n_chk++;
        if ({cmd, start_cmd, grant_id, busy, pend, timeout_err, overrun} !== RESET_VEC)
            $display("FAIL mid_async_reset: got %h required %h",
                     {cmd, start_cmd, grant_id, busy, pend, timeout_err, overrun}, RESET_VEC);
        else n_pass++;
        @(negedge clk);
        req_r = 1'b0;
        rst = 1'b1;
        pulse_done();
        saw = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (start_cmd === 1'b1) saw = 1'b1;
        end
        n_chk++;
        if ({saw, pend} !== {1'b0, 3'b000})
            $display("FAIL mid_no_start: got start_seen=%b pend=%b required 0 000", saw, pend);
        else n_pass++;
        req_e = 1'b1; req_r = 1'b1; row_e = 24'h000007; row_r = 24'h000008;
        @(negedge clk);
        req_e = 1'b0; req_r = 1'b0;
        wait_start("mid_restart", 10, waited);
        n_chk++;
        if ({grant_id, cmd} !== {2'd0, 32'h60000007})
            $display("FAIL mid_first_grant: got gid=%0d cmd=%h required 0 60000007", grant_id, cmd);
        else n_pass++;
        @(negedge clk);
        pulse_done();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single_write();
        test_overrun();
        test_timeout();
        test_same_cycle();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
